// File: rtl/relm_adc_seq_pkg.sv
// Shared types and helpers for the ADC128S022 sequencer: frame FSM states,
// command/result field positions and the channel scheduling helpers.
package relm_adc_seq_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} adc_state_t;

  localparam int CMD_CONT_BIT = 8;
  localparam int RES_BUSY_BIT = 15;
  localparam int RES_CH_LSB   = 12;
  localparam int ADD_MSB_BIT  = 2;
  localparam int ADD_LSB_BIT  = 4;
  localparam int FRAME_BITS   = 16;
  localparam int DATA_OFS     = 4;
  localparam int SAMPLE_W     = FRAME_BITS - DATA_OFS;

  // DIN value for a given frame bit: ADD2..ADD0 on bits 2..4, zero elsewhere
  function automatic logic addr_bit(input logic [2:0] addr, input logic [3:0] bidx);
    if (int'(bidx) == ADD_MSB_BIT)          return addr[2];
    else if (int'(bidx) == ADD_MSB_BIT + 1) return addr[1];
    else if (int'(bidx) == ADD_LSB_BIT)     return addr[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, m[i]};
    return n;
  endfunction

  // First enabled channel at or after 'from', wrapping 7->0
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] from);
    logic [2:0] c;
    logic [2:0] sel;
    sel = from;
    for (int i = 7; i >= 0; i--) begin
      c = from + 3'(i);
      if (m[c]) sel = c;
    end
    return sel;
  endfunction

endpackage

// File: rtl/relm_adc_seq_frame.sv
// One CS/SCLK/DIN/DOUT frame of the ADC128S022 protocol: setup, 16 SCLK
// periods, then CS_n high for HOLD cycles; o_done pulses on the last hold cycle.
module relm_adc_seq_frame
  import relm_adc_seq_pkg::*;
#(
  parameter int DIV  = 8,
  parameter int HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                i_start,
  input  logic [2:0]          i_addr,
  input  logic                i_sdat,
  output logic                o_cs_n,
  output logic                o_sclk,
  output logic                o_saddr,
  output logic                o_busy,
  output logic                o_done,
  output logic [SAMPLE_W-1:0] o_data
);

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HOLD_M1 = 16'(HOLD - 1);
  localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

  adc_state_t          r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [3:0]          r_bit;
  logic [2:0]          r_addr;
  logic                r_cs_n, r_sclk, r_saddr;
  logic                r_s1, r_s2;
  logic [SAMPLE_W-1:0] r_sh;
  logic                w_half, w_hold_end;

  assign w_half     = (r_cnt == DIV_M1);
  assign w_hold_end = (r_state == ST_HOLD) && (r_cnt == HOLD_M1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_half) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_half && r_sclk && r_bit == LAST_BIT) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_hold_end) w_state_nxt = i_start ? ST_SETUP : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DOUT synchronizer and sample shift register; the register keeps only
  // the last 12 bits shifted, which are frame bits 4..15
  always_ff @(posedge clk) begin
    r_s1 <= i_sdat;
    r_s2 <= r_s1;
    if (r_state == ST_SHIFT && w_half && !r_sclk) r_sh <= {r_sh[SAMPLE_W-2:0], r_s2};
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_addr  <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_saddr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_start) begin
            r_cs_n <= 1'b0;
            r_addr <= i_addr;
          end
        end
        ST_SETUP: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_saddr <= addr_bit(r_addr, 4'd0);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_SHIFT: begin
          if (!w_half) begin
            r_cnt <= r_cnt + 16'd1;
          end else begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (r_bit == LAST_BIT) begin
              r_cs_n  <= 1'b1;
              r_saddr <= 1'b0;
            end else begin
              r_sclk  <= 1'b0;
              r_bit   <= r_bit + 4'd1;
              r_saddr <= addr_bit(r_addr, r_bit + 4'd1);
            end
          end
        end
        ST_HOLD: begin
          if (w_hold_end) begin
            r_cnt <= '0;
            if (i_start) begin
              r_cs_n <= 1'b0;
              r_addr <= i_addr;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_cs_n  = r_cs_n;
  assign o_sclk  = r_sclk;
  assign o_saddr = r_saddr;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = w_hold_end;
  assign o_data  = r_sh;

endmodule

// File: rtl/relm_adc_seq.sv
// ADC128S022 sequencer: command push slot, channel scheduler, 8-entry result
// bank with fresh flags behind a pop port, driving one frame engine.
module relm_adc_seq
  import relm_adc_seq_pkg::*;
#(
  parameter int WD   = 32,
  parameter int DIV  = 8,
  parameter int HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [WD:0] cmd_d,
  output logic        cmd_retry,
  input  logic [WD:0] res_d,
  output logic [WD:0] res_q,
  output logic        adc_cs_n_out,
  output logic        adc_saddr_out,
  output logic        adc_sclk_out,
  input  logic        adc_sdat_in
);

  logic [7:0]          r_mask;
  logic                r_cont;
  logic [3:0]          r_left;
  logic [2:0]          r_last_ch;
  logic [2:0]          r_cur_addr, r_prev_addr;
  logic                r_cur_real, r_prev_vld;
  logic [7:0]          r_fresh;
  logic [SAMPLE_W-1:0] r_bank [8];

  logic                w_busy, w_done, w_start, w_real;
  logic [2:0]          w_addr, w_from, w_nch, w_pop_ch;
  logic [SAMPLE_W-1:0] w_data;
  logic                w_unused_bits;

  assign w_unused_bits = ^{cmd_d[WD-1:CMD_CONT_BIT+1], res_d[WD-1:3]};
  assign w_pop_ch      = res_d[2:0];
  assign w_from        = w_busy ? (r_last_ch + 3'd1) : 3'd0;
  assign w_nch         = next_ch(r_mask, w_from);

  // Frame boundary: engine idle or finishing its hold. A single-shot run ends
  // with one extra frame addressed to ch0 that only collects the last sample.
  always_comb begin
    w_start = 1'b0;
    w_addr  = w_nch;
    w_real  = 1'b1;
    if ((!w_busy || w_done) && r_mask != 8'd0) begin
      if (r_cont || r_left != 4'd0) begin
        w_start = 1'b1;
      end else if (w_busy && r_cur_real) begin
        w_start = 1'b1;
        w_addr  = 3'd0;
        w_real  = 1'b0;
      end
    end
  end

  relm_adc_seq_frame #(
    .DIV  (DIV),
    .HOLD (HOLD)
  ) u_frame (
    .clk     (clk),
    .rst_in  (rst_in),
    .i_start (w_start),
    .i_addr  (w_addr),
    .i_sdat  (adc_sdat_in),
    .o_cs_n  (adc_cs_n_out),
    .o_sclk  (adc_sclk_out),
    .o_saddr (adc_saddr_out),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_data  (w_data)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_mask      <= '0;
      r_cont      <= 1'b0;
      r_left      <= '0;
      r_last_ch   <= '0;
      r_cur_addr  <= '0;
      r_prev_addr <= '0;
      r_cur_real  <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_fresh     <= '0;
      r_bank      <= '{default: '0};
    end else begin
      if (w_start) begin
        r_prev_addr <= r_cur_addr;
        r_prev_vld  <= w_busy && r_cur_real;
        r_cur_addr  <= w_addr;
        r_cur_real  <= w_real;
        if (w_real) begin
          r_last_ch <= w_addr;
          if (!r_cont && r_left != 4'd0) r_left <= r_left - 4'd1;
        end
      end
      // Pop clear first so a same-cycle result write leaves the entry fresh
      if (res_d[WD] && r_fresh[w_pop_ch]) r_fresh[w_pop_ch] <= 1'b0;
      if (w_done && r_prev_vld) begin
        r_bank[r_prev_addr]  <= w_data;
        r_fresh[r_prev_addr] <= 1'b1;
      end
      if (cmd_d[WD]) begin
        r_mask <= cmd_d[7:0];
        r_cont <= cmd_d[CMD_CONT_BIT];
        r_left <= popcount8(cmd_d[7:0]);
      end
    end
  end

  always_comb begin
    res_q                        = '0;
    res_q[WD]                    = ~r_fresh[w_pop_ch];
    res_q[RES_BUSY_BIT]          = w_busy;
    res_q[RES_CH_LSB +: 3]       = w_pop_ch;
    res_q[SAMPLE_W-1:0]          = r_bank[w_pop_ch];
  end

  assign cmd_retry = 1'b0;

endmodule

// File: doc/relm_adc_seq.md
Name: relm_adc_seq

Overview:
- Hardware sequencer for the on-board 8-channel, 12-bit serial ADC (ADC128S022 protocol).
- Replaces software bit-banging of the ADC pins: the CPU writes a channel mask once, and the block runs 16-bit serial frames autonomously.
- Latest sample per channel is held in an 8-entry result bank, read through a pop port.
- Sits beside the other push/pop I/O in the top level: one push slot (command) and one pop slot (result).

Parameters:
- WD, 32, data word width; push/pop buses are WD+1 bits, with bit WD as the strobe/flag.
- DIV, 8, clk cycles per SCLK half-period; legal range 4..255; 8 gives 3.125 MHz at 50 MHz.
- HOLD, 8, clk cycles CS_n stays high between frames; minimum 1.

Ports:
- clk, input, 1: sole clock.
- rst_in, input, 1: synchronous, active-high reset.
- cmd_d, input, WD+1: push from CPU.
  - [WD] write strobe.
  - [7:0] channel mask.
  - [8] continuous (1) / single-shot (0).
- cmd_retry, output, 1: tied 0; commands are always accepted.
- res_d, input, WD+1: pop request.
  - [WD] pop strobe.
  - [2:0] channel to read.
- res_q, output, WD+1: pop data.
  - [WD] = ~fresh[ch].
  - [15] busy.
  - [14:12] ch.
  - [11:0] sample.
  - all other bits 0.
- adc_cs_n_out, output, 1: chip select, active low.
- adc_saddr_out, output, 1: serial address (DIN).
- adc_sclk_out, output, 1: serial clock, idles high.
- adc_sdat_in, input, 1: serial data (DOUT), asynchronous.

Behaviour:
- Reset values:
  - Outputs: cs_n=1, sclk=1, saddr=0.
  - Internal: mask=0, cont=0, state=IDLE, fresh=0, result bank=0.
- Reset mid-frame aborts the frame immediately: cs_n goes high on the next edge and no partial result is written.
- adc_sdat_in passes through a 2-flop synchronizer inside the block.
- Commands:
  - On cmd_d[WD]=1, mask and cont are latched.
  - A new non-zero mask is picked up at the next frame boundary.
  - mask=0 stops the block after the current frame; that frame's result is still written.
  - A command in IDLE with mask≠0 starts a sequence on the next cycle.
- States:
  - IDLE → SETUP: when mask≠0.
  - SETUP: cs_n=0, sclk=1 for DIV cycles → SHIFT.
  - SHIFT: 16 SCLK periods, each DIV cycles low then DIV cycles high.
    - saddr changes only on a falling SCLK edge.
    - Bits 2,3,4 of the frame carry ADD2..ADD0; all other bits are 0.
    - On each rising SCLK edge, the synchronized sdat shifts into a 16-bit register.
    - After bit 15 → HOLD.
  - HOLD: cs_n=1 for HOLD cycles, then:
    - → SETUP if more frames are due;
    - → IDLE otherwise.
- Pipelining:
  - The address sent in frame k selects the data returned in frame k+1.
  - The first frame after IDLE is a dummy: its data is discarded.
  - For frame k≥1, bits [11:0] of the shift register (frame bits 4..15) are written to bank[addr(k-1)] and fresh[addr(k-1)] is set.
- Channel order: next enabled channel in ascending index after the previous one, wrapping 7→0.
- Single-shot:
  - Runs popcount(mask)+1 frames.
  - The last frame carries address 0, which is not stored.
  - Then the block returns to IDLE.
- Continuous: runs until mask=0 or reset.
- busy = (state≠IDLE).
- Result read path:
  - res_q is combinational from res_d[2:0] and registered state.
  - On res_d[WD]=1 with fresh[ch]=1, fresh[ch] clears on that edge.
  - When fresh[ch]=0, res_q[WD]=1 signals retry; the CPU stalls until a new sample arrives. Reading a channel that is not enabled therefore blocks indefinitely (documented software rule).
- Simultaneous result write and pop clear on the same channel: the set wins, and the new data stays fresh.
- Frame length: 2*DIV*16 + DIV + HOLD cycles, which is 272 cycles at defaults.

Decomposition:
- relm_adc_defs.vh (shared include):
  - state encodings;
  - cmd and res bit positions;
  - ADD bit indices (2..4);
  - data field offset (4).
- Sub-module relm_adc_frame: one CS/SCLK/DIN/DOUT frame engine.
  - Inputs: start, addr[2:0].
  - Outputs: done pulse, data[11:0].
- The top level holds the mask, channel scheduler, result bank and fresh flags.

Test Plan:
- Bench ADC model: captures DIN on SCLK rise, drives DOUT on SCLK fall. Channel n returns 0x100*n+0x23, and the model checks tCSS≥DIV and SCLK idle high.
- Reset, then idle 50 cycles → cs_n=1, sclk=1, saddr=0, res_q[WD]=1 for every ch, busy=0.
- Push mask=0x01, cont=0:
  - 2 frames, 544 cycles;
  - first frame DIN address 0;
  - pop ch0 returns 0x023 with res_q[WD]=0 and busy=0;
  - a second pop of ch0 returns retry.
- Push mask=0x85, cont=0:
  - addresses in order 0,2,7,0 across 4 frames;
  - bank holds ch0=0x023, ch2=0x223, ch7=0x723;
  - ch1 stays not-fresh.
- Push mask=0x03, cont=1, then mask=0 after 3 frames → the current frame completes, cs_n goes high, busy=0 and no further SCLK edges occur. The results collected so far alternate ch0/ch1.
- Assert rst_in at bit 7 of SHIFT → cs_n=1 and sclk=1 the next cycle, no fresh bit is set, mask=0.
- Pop ch2 in the same cycle its new result is written → fresh[2] stays 1, and the next pop returns the new value.
